// File: rtl/anc_pkg.sv
// -----------------------------------------------------------------------------
// anc_pkg
// Shared definitions for the ANC control and filter blocks: sequencer state
// encoding and the default filter/timeout dimensions.
// -----------------------------------------------------------------------------
package anc_pkg;

    localparam int ANC_TAPS_DEF    = 32;
    localparam int ANC_TAP_W_DEF   = 5;
    localparam int ANC_TIMEOUT_DEF = 64;
    localparam int ANC_CNT_W_DEF   = 8;

    localparam logic [2:0] ANC_ST_IDLE   = 3'd0;
    localparam logic [2:0] ANC_ST_SHIFT  = 3'd1;
    localparam logic [2:0] ANC_ST_FILTER = 3'd2;
    localparam logic [2:0] ANC_ST_WAIT   = 3'd3;
    localparam logic [2:0] ANC_ST_UPDATE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = ANC_ST_IDLE,
        ST_SHIFT  = ANC_ST_SHIFT,
        ST_FILTER = ANC_ST_FILTER,
        ST_WAIT   = ANC_ST_WAIT,
        ST_UPDATE = ANC_ST_UPDATE
    } anc_state_e;

endpackage

// File: rtl/anc_pulse_sync.sv
// -----------------------------------------------------------------------------
// anc_pulse_sync
// Brings an asynchronous strobe into the clk domain through two flops and
// emits a one-cycle pulse on its synchronized rising edge.
//   clk       in  destination clock
//   rst_n     in  asynchronous active-low reset
//   async_in  in  strobe from another clock domain
//   pulse_out out one-cycle pulse, high in the cycle before the 3rd clk edge
//                 after async_in rises
// -----------------------------------------------------------------------------
module anc_pulse_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic pulse_out
);

    // [0],[1] form the synchronizer; [2] is the edge-detect history
    logic [2:0] sync_d;
    logic [2:0] sync_q;

    // Shift the input through the synchronizer chain
    always_comb begin
        sync_d = {sync_q[1:0], async_in};
    end

    // Synchronizer and history flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign pulse_out = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/anc_sample_scheduler.sv
// -----------------------------------------------------------------------------
// anc_sample_scheduler
// Per-sample sequencer for the ANC datapath: on each accepted sample-ready
// strobe it shifts the data RAM, runs a TAPS-cycle filter pass, waits for the
// filter to report completion and issues one saturation/output update.
//   Clk_100M        in  system clock
//   Reset           in  asynchronous active-low reset
//   SSPIF_In        in  sample-ready from the SPI block (async)
//   Enable          in  1 = accept new samples
//   FiltComplete_In in  filter pass done, looked at only while waiting
//   ClearFlags      in  synchronous clear of Overrun/Timeout/OverrunCnt
//   RAMDataEN       out one-cycle data RAM shift strobe
//   FilterEN        out high for TAPS consecutive cycles
//   TapIdx          out tap index during FilterEN, else 0
//   SatEN           out one-cycle saturation/output update strobe
//   Busy            out sequence in progress
//   Overrun         out sticky: a sample was lost
//   Timeout         out sticky: filter completion never arrived
//   OverrunCnt      out saturating count of lost samples
// -----------------------------------------------------------------------------
module anc_sample_scheduler
    import anc_pkg::*;
#(
    parameter int TAPS    = ANC_TAPS_DEF,
    parameter int TAP_W   = ANC_TAP_W_DEF,
    parameter int TIMEOUT = ANC_TIMEOUT_DEF,
    parameter int CNT_W   = ANC_CNT_W_DEF
) (
    input  logic             Clk_100M,
    input  logic             Reset,
    input  logic             SSPIF_In,
    input  logic             Enable,
    input  logic             FiltComplete_In,
    input  logic             ClearFlags,
    output logic             RAMDataEN,
    output logic             FilterEN,
    output logic [TAP_W-1:0] TapIdx,
    output logic             SatEN,
    output logic             Busy,
    output logic             Overrun,
    output logic             Timeout,
    output logic [CNT_W-1:0] OverrunCnt
);

    localparam int               TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic req_s;
    logic acc_s;
    logic ovr_evt_s;
    logic tout_evt_s;

    anc_state_e       state_d, state_q;
    logic [TAP_W-1:0] tap_d, tap_q;
    logic [TMR_W-1:0] tmr_d, tmr_q;
    logic             pend_d, pend_q;
    logic             ovr_d, ovr_q;
    logic             tout_d, tout_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             ram_en_d, ram_en_q;
    logic             filt_en_d, filt_en_q;
    logic [TAP_W-1:0] tap_idx_d, tap_idx_q;
    logic             sat_en_d, sat_en_q;
    logic             busy_d, busy_q;

    anc_pulse_sync u_sspif_sync (
        .clk       (Clk_100M),
        .rst_n     (Reset),
        .async_in  (SSPIF_In),
        .pulse_out (req_s)
    );

    assign acc_s = req_s & Enable;

    // Sequencer next state, tap counter, wait timer and one-deep pending flag
    always_comb begin
        state_d    = state_q;
        tap_d      = tap_q;
        tmr_d      = tmr_q;
        pend_d     = pend_q;
        ovr_evt_s  = 1'b0;
        tout_evt_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (acc_s || pend_q) begin
                    state_d = ST_SHIFT;
                    // A sample landing together with a pending one is served
                    // as the pending one, the new one takes the pending slot
                    pend_d  = acc_s & pend_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                state_d = ST_FILTER;
                tap_d   = {TAP_W{1'b0}};
            end
            ST_FILTER: begin
                if (tap_q == TAP_LAST) begin
                    state_d = ST_WAIT;
                    tap_d   = {TAP_W{1'b0}};
                    tmr_d   = {TMR_W{1'b0}};
                end else begin
                    tap_d   = tap_q + TAP_W'(1);
                end
            end
            ST_WAIT: begin
                if (FiltComplete_In) begin
                    state_d = ST_UPDATE;
                end else if (tmr_q == TMR_LAST) begin
                    state_d    = ST_IDLE;
                    tout_evt_s = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_UPDATE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                tap_d   = {TAP_W{1'b0}};
                tmr_d   = {TMR_W{1'b0}};
            end
        endcase
        // Samples arriving mid-sequence fill the pending slot or are lost
        if (acc_s && (state_q != ST_IDLE)) begin
            if (pend_q) begin
                ovr_evt_s = 1'b1;
            end else begin
                pend_d = 1'b1;
            end
        end else begin
            ovr_evt_s = 1'b0;
        end
    end

    // Sticky status with clear taking priority, and registered strobe decode
    always_comb begin
        ovr_d  = ovr_q;
        tout_d = tout_q;
        cnt_d  = cnt_q;
        if (ClearFlags) begin
            ovr_d  = 1'b0;
            tout_d = 1'b0;
            cnt_d  = {CNT_W{1'b0}};
        end else begin
            if (ovr_evt_s) begin
                ovr_d = 1'b1;
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end else begin
                ovr_d = ovr_q;
            end
            if (tout_evt_s) begin
                tout_d = 1'b1;
            end else begin
                tout_d = tout_q;
            end
        end
        // Strobes are decoded from the next state so they line up with it
        ram_en_d  = (state_d == ST_SHIFT);
        filt_en_d = (state_d == ST_FILTER);
        tap_idx_d = (state_d == ST_FILTER) ? tap_d : {TAP_W{1'b0}};
        sat_en_d  = (state_d == ST_UPDATE);
        busy_d    = (state_d != ST_IDLE);
    end

    // State, counters, status and output registers
    always_ff @(posedge Clk_100M or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_IDLE;
            tap_q     <= {TAP_W{1'b0}};
            tmr_q     <= {TMR_W{1'b0}};
            pend_q    <= 1'b0;
            ovr_q     <= 1'b0;
            tout_q    <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
            ram_en_q  <= 1'b0;
            filt_en_q <= 1'b0;
            tap_idx_q <= {TAP_W{1'b0}};
            sat_en_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            tmr_q     <= tmr_d;
            pend_q    <= pend_d;
            ovr_q     <= ovr_d;
            tout_q    <= tout_d;
            cnt_q     <= cnt_d;
            ram_en_q  <= ram_en_d;
            filt_en_q <= filt_en_d;
            tap_idx_q <= tap_idx_d;
            sat_en_q  <= sat_en_d;
            busy_q    <= busy_d;
        end
    end

    assign RAMDataEN  = ram_en_q;
    assign FilterEN   = filt_en_q;
    assign TapIdx     = tap_idx_q;
    assign SatEN      = sat_en_q;
    assign Busy       = busy_q;
    assign Overrun    = ovr_q;
    assign Timeout    = tout_q;
    assign OverrunCnt = cnt_q;

endmodule
